serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences one instance of the team's 1-bit `full_adder` across a WIDTH-bit operand pair, LSB first, one bit per clock, and returns the sum, carry-out and signed-overflow through a start/done handshake. It is the word-level wrapper that lets the single-bit adder cell serve as a multi-bit arithmetic resource in gate-level designs.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and sizing for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // The bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell reused by word-level arithmetic wrappers.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: drives one full_adder LSB-first over WIDTH bits,
// returning sum, carry-out and signed overflow through a start/done handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   res_q,   res_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic               fa_sum;
    logic               fa_carry;

    full_adder u_full_adder (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                done    = (state_q == S_DONE);
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                busy    = 1'b1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this last bit.
                    sum_d   = res_d;
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: behavioural model, directed cases, random traffic.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_en = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request finishes W cycles later with a+b+cin.
    int           m_left = 0;
    bit           m_done = 0;
    logic [W-1:0] m_sum = '0;
    bit           m_cout = 0;
    bit           m_ovf = 0;
    logic [W-1:0] p_sum;
    bit           p_cout;
    bit           p_ovf;

    function automatic longint as_signed(input logic [W-1:0] v);
        return v[W-1] ? longint'(v) - (longint'(1) << W) : longint'(v);
    endfunction

    always @(posedge clk) begin
        longint total;
        longint stotal;
        if (rst) begin
            m_left = 0;
            m_done = 0;
            m_sum  = '0;
            m_cout = 0;
            m_ovf  = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_sum  = p_sum;
                    m_cout = p_cout;
                    m_ovf  = p_ovf;
                end
            end else if (start) begin
                total  = longint'(a) + longint'(b) + longint'(cin);
                stotal = as_signed(a) + as_signed(b) + longint'(cin);
                p_sum  = total[W-1:0];
                p_cout = total[W];
                p_ovf  = (stotal > (longint'(1) << (W - 1)) - 1) || (stotal < -(longint'(1) << (W - 1)));
                m_left = W;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("done", {31'd0, done}, {31'd0, m_done});
            check("sum",  {24'd0, sum},  {24'd0, m_sum});
            check("cout", {31'd0, cout}, {31'd0, m_cout});
            check("ovf",  {31'd0, ovf},  {31'd0, m_ovf});
        end
    end

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        a = ia;
        b = ib;
        cin = ic;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        busy_cycles = 0;
        seen = 0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        check({tag, "_sum"},  {24'd0, sum},  {24'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    endtask

    initial begin
        int bc;
        int nd;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);

        start_op(8'h00, 8'h00, 1'b0);
        wait_done(bc);
        check("zero_busy_cycles", bc, W);
        check_result("zero", 8'h00, 1'b0, 1'b0);

        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(bc);
        check("ff01_busy_cycles", bc, W);
        check_result("ff01", 8'h00, 1'b1, 1'b0);

        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(bc);
        check_result("7f01", 8'h80, 1'b0, 1'b1);

        // Back-to-back: request issued during the done cycle.
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done(bc);
        check_result("a55a", 8'h00, 1'b1, 1'b0);
        start_op(8'h03, 8'h04, 1'b0);
        wait_done(bc);
        check("b2b_busy_cycles", bc, W);
        check_result("b2b", 8'h07, 1'b0, 1'b0);

        // A start pulse mid-add must be ignored.
        start_op(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(bc);
        check_result("ignore", 8'h46, 1'b0, 1'b0);
        count_done(3 * W, nd);
        check("ignore_extra_done", nd, 0);

        // Reset mid-add aborts without a done pulse.
        start_op(8'h11, 8'h22, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check_result("abort", 8'h00, 1'b0, 1'b0);
        count_done(3 * W, nd);
        check("abort_no_done", nd, 0);
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(bc);
        check_result("after_abort", 8'h30, 1'b0, 1'b0);

        // Random traffic, checked every cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            rst   = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (2 * W) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
